// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared encodings for unidade_controle (HALT state exists only with UC_ILLEGAL_TRAP_EN)
package uc_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_R  = 4'b0000;
    localparam logic [3:0] ALU_I  = 4'b0001;
    localparam logic [3:0] ALU_S  = 4'b0010;
    localparam logic [3:0] ALU_SB = 4'b0011;
    localparam logic [3:0] ALU_U  = 4'b0100;
    localparam logic [3:0] ALU_UJ = 4'b0101;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_MSB  = 1;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
`ifdef UC_ILLEGAL_TRAP_EN
        , ST_HALT
`endif
    } uc_state_e;

    typedef enum logic [2:0] {
        CLS_OP,
        CLS_OP_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_ILLEGAL
    } uc_class_e;

endpackage

// File: rtl/uc_decoder.sv
// rtl/uc_decoder.sv - combinational opcode to class / alu_cmd / alu_src mapping
module uc_decoder
    import uc_pkg::*;
(
    input  logic [6:0] opcode,
    output uc_class_e  cls,
    output logic [3:0] alu_cmd,
    output logic       alu_src
);

    always_comb begin
        cls     = CLS_ILLEGAL;
        alu_cmd = ALU_R;
        alu_src = 1'b0;
        case (opcode)
            OPC_OP:     begin cls = CLS_OP;     alu_cmd = ALU_R;  alu_src = 1'b0; end
            OPC_OP_IMM: begin cls = CLS_OP_IMM; alu_cmd = ALU_I;  alu_src = 1'b1; end
            OPC_LOAD:   begin cls = CLS_LOAD;   alu_cmd = ALU_I;  alu_src = 1'b1; end
            OPC_STORE:  begin cls = CLS_STORE;  alu_cmd = ALU_S;  alu_src = 1'b1; end
            OPC_BRANCH: begin cls = CLS_BRANCH; alu_cmd = ALU_SB; alu_src = 1'b0; end
            OPC_LUI:    begin cls = CLS_LUI;    alu_cmd = ALU_U;  alu_src = 1'b1; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multi-cycle RISC-V control FSM; UC_ILLEGAL_TRAP_EN makes illegal opcodes halt
module unidade_controle
    import uc_pkg::*;
#(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [3:0]          alu_flags,
    output logic                d_mem_we,
    output logic                rf_we,
    output logic                pc_we,
    output logic [3:0]          alu_cmd,
    output logic                alu_src,
    output logic                pc_src,
    output logic                rf_src,
    output logic [CNT_BITS-1:0] instret,
    output logic                halted
);

    uc_state_e           state_q, state_d;
    logic [6:0]          opcode_q, opcode_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [CNT_BITS-1:0] instret_q, instret_d;

    logic [6:0] dec_opcode;
    uc_class_e  cls;
    logic [3:0] dec_cmd;
    logic       dec_src;
    logic       taken;
    logic       unused_flags;

    assign unused_flags = ^alu_flags[3:2];

    // DECODE sees the live instruction register; later states use the latched copy
    assign dec_opcode = (state_q == ST_DECODE) ? opcode : opcode_q;

    uc_decoder u_decoder (
        .opcode  (dec_opcode),
        .cls     (cls),
        .alu_cmd (dec_cmd),
        .alu_src (dec_src)
    );

    always_comb begin
        taken = 1'b0;
        case (funct3_q)
            F3_BEQ:  taken = alu_flags[FLAG_ZERO];
            F3_BNE:  taken = !alu_flags[FLAG_ZERO];
            F3_BLT:  taken = alu_flags[FLAG_MSB];
            F3_BGE:  taken = !alu_flags[FLAG_MSB];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct3_d = funct3_q;
        d_mem_we = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        rf_src   = 1'b0;
        alu_cmd  = ALU_R;
        alu_src  = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                alu_cmd  = dec_cmd;
                alu_src  = dec_src;
                opcode_d = opcode;
                funct3_d = funct3;
                if (cls == CLS_ILLEGAL) begin
`ifdef UC_ILLEGAL_TRAP_EN
                    state_d = ST_HALT;
`else
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_cmd = dec_cmd;
                alu_src = dec_src;
                case (cls)
                    CLS_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = taken;
                        state_d = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                alu_cmd = dec_cmd;
                alu_src = dec_src;
                if (cls == CLS_STORE) begin
                    d_mem_we = 1'b1;
                    pc_we    = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                alu_cmd = dec_cmd;
                alu_src = dec_src;
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                rf_src  = (cls == CLS_LOAD);
                state_d = ST_FETCH;
            end
`ifdef UC_ILLEGAL_TRAP_EN
            ST_HALT: halted = 1'b1;
`endif
            default: state_d = ST_FETCH;
        endcase
        instret_d = pc_we ? instret_q + CNT_BITS'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            funct3_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - randomized self-checking bench for unidade_controle (CNT_BITS=4)
module tb_unidade_controle;

    localparam logic [6:0] T_OP  = 7'b0110011;
    localparam logic [6:0] T_IMM = 7'b0010011;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_SD  = 7'b0100011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [3:0] alu_flags = '0;
    logic       d_mem_we, rf_we, pc_we, alu_src, pc_src, rf_src, halted;
    logic [3:0] alu_cmd;
    logic [3:0] instret;

    int n_pass = 0;
    int n_total = 0;
    int retired = 0;

    unidade_controle #(.CNT_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .alu_flags(alu_flags),
        .d_mem_we(d_mem_we), .rf_we(rf_we), .pc_we(pc_we), .alu_cmd(alu_cmd),
        .alu_src(alu_src), .pc_src(pc_src), .rf_src(rf_src), .instret(instret), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [10:0] obs();
        return {halted, d_mem_we, rf_we, pc_we, alu_cmd, alu_src, pc_src, rf_src};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {T_OP, T_IMM, T_LD, T_SD, T_BR, T_LUI};
    endfunction

    function automatic int latency(input logic [6:0] op);
        case (op)
            T_OP, T_IMM, T_LUI, T_SD: return 4;
            T_LD:                     return 5;
            T_BR:                     return 3;
            default:                  return 2;
        endcase
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input logic [3:0] fl);
        case (f3)
            3'b000:  return fl[0];
            3'b001:  return !fl[0];
            3'b100:  return fl[1];
            3'b101:  return !fl[1];
            default: return 1'b0;
        endcase
    endfunction

    // Expected outputs for cycle k (0 = FETCH) of an instruction lasting lat cycles
    function automatic logic [10:0] expect_vec(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [3:0] fl, input int k, input int lat);
        logic [3:0] cmd;
        logic src, last, dm, rw, pw, ps, rs;
        cmd = 4'd0;
        src = 1'b0;
        if (k >= 1) begin
            case (op)
                T_IMM, T_LD: begin cmd = 4'd1; src = 1'b1; end
                T_SD:        begin cmd = 4'd2; src = 1'b1; end
                T_BR:        begin cmd = 4'd3; src = 1'b0; end
                T_LUI:       begin cmd = 4'd4; src = 1'b1; end
                default:     begin cmd = 4'd0; src = 1'b0; end
            endcase
        end
        last = (k == lat - 1);
`ifdef UC_ILLEGAL_TRAP_EN
        pw = last && is_legal(op);
`else
        pw = last;
`endif
        rw = last && (op inside {T_OP, T_IMM, T_LUI, T_LD});
        dm = last && (op == T_SD);
        rs = last && (op == T_LD);
        ps = last && (op == T_BR) && br_taken(f3, fl);
        return {1'b0, dm, rw, pw, cmd, src, ps, rs};
    endfunction

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] fl,
                        input bit rnd, input int k, input int lat, input string tag);
        opcode    = (k == 1) ? op : 7'($urandom);
        funct3    = (k == 1) ? f3 : 3'($urandom);
        alu_flags = rnd ? 4'($urandom) : fl;
        @(negedge clk);
        check($sformatf("%s/c%0d", tag, k), 32'(obs()), 32'(expect_vec(op, f3, alu_flags, k, lat)));
    endtask

    // Entered and left at posedge+1 of a FETCH cycle
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] fl,
                             input bit rnd, input string tag);
        int lat;
        lat = latency(op);
        for (int k = 0; k < lat; k++) begin
            step(op, f3, fl, rnd, k, lat, tag);
            @(posedge clk);
            #1;
        end
`ifdef UC_ILLEGAL_TRAP_EN
        if (is_legal(op)) retired++;
`else
        retired++;
`endif
        check({tag, "/instret"}, 32'(instret), 32'(retired % 16));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        retired = 0;
        @(negedge clk);
        check({tag, "/rst_out"}, 32'(obs()), 32'd0);
        check({tag, "/rst_cnt"}, 32'(instret), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] op;
        do_reset("por");

        run_instr(T_OP, 3'd0, 4'd0, 1'b1, "add");
        run_instr(T_LD, 3'd3, 4'd0, 1'b1, "ld");
        run_instr(T_SD, 3'd3, 4'd0, 1'b1, "sd");
        run_instr(T_BR, 3'b000, 4'b0001, 1'b0, "beq");
        run_instr(T_BR, 3'b001, 4'b0001, 1'b0, "bne");
        run_instr(T_BR, 3'b100, 4'b0010, 1'b0, "blt");
        run_instr(T_BR, 3'b101, 4'b0010, 1'b0, "bge");
        run_instr(T_LUI, 3'd0, 4'd0, 1'b1, "lui");

        // Reset landing on the edge that would enter MEM of a store
        for (int k = 0; k < 3; k++) begin
            step(T_SD, 3'd3, 4'd0, 1'b1, k, 4, "sd_rst");
            if (k < 2) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        rst_n = 1'b0;
        retired = 0;
        #1;
        check("sd_rst/async_out", 32'(obs()), 32'd0);
        check("sd_rst/async_cnt", 32'(instret), 32'd0);
        @(negedge clk);
        check("sd_rst/hold_out", 32'(obs()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(T_OP, 3'd0, 4'd0, 1'b1, "after_rst");

        do_reset("wrap_rst");
        for (int i = 0; i < 16; i++) run_instr(T_IMM, 3'd0, 4'd0, 1'b1, "wrap_fill");
        check("wrap/zero", 32'(instret), 32'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: op = T_OP;
                1: op = T_IMM;
                2: op = T_LD;
                3: op = T_SD;
                4: op = T_BR;
                5: op = T_LUI;
                default: op = 7'($urandom);
            endcase
`ifdef UC_ILLEGAL_TRAP_EN
            if (!is_legal(op)) op = T_OP;
`endif
            run_instr(op, 3'($urandom), 4'($urandom), 1'b1, $sformatf("rnd%0d", i));
        end

        run_instr(7'b1111111, 3'd0, 4'd0, 1'b1, "illegal");
`ifdef UC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) begin
            opcode    = 7'($urandom);
            alu_flags = 4'($urandom);
            @(negedge clk);
            check($sformatf("halt/c%0d", i), 32'(obs()), 32'h400);
            check($sformatf("halt_cnt/c%0d", i), 32'(instret), 32'(retired % 16));
            @(posedge clk);
            #1;
        end
        do_reset("halt_rst");
        run_instr(T_OP, 3'd0, 4'd0, 1'b1, "after_halt");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
